// File: rtl/router_pkt_tx_pkg.sv
// Shared definitions for the router packet transmitter: field widths, header
// layout and FSM state encoding.
package router_pkt_tx_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    localparam int HDR_LEN_MSB  = 7;
    localparam int HDR_LEN_LSB  = 2;
    localparam int HDR_ADDR_MSB = 1;
    localparam int HDR_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY
    } state_t;

    function automatic logic [DATA_W-1:0] make_header(input logic [LEN_W-1:0]  len,
                                                      input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] h;
        h = '0;
        h[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        h[HDR_ADDR_MSB:HDR_ADDR_LSB] = addr;
        return h;
    endfunction

endpackage

// File: rtl/router_pkt_tx_buf.sv
// Payload buffer: simple dual-port RAM, synchronous write, registered read.
module router_pkt_tx_buf #(
    parameter int AW = 6,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a whole payload, then sends header, payload
// and parity gap-free on the datain/packet_valid/busy interface.
module router_pkt_tx
    import router_pkt_tx_pkg::*;
#(
    parameter int BUF_AW = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  pay_len,
    input  logic              inj_err,
    input  logic              pl_valid,
    input  logic [DATA_W-1:0] pl_data,
    output logic              pl_ready,
    input  logic              busy,
    output logic [DATA_W-1:0] tx_data,
    output logic              packet_valid,
    output logic              idle,
    output logic              done,
    output logic              addr_err
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic              inj_reg;
    logic [LEN_W-1:0]  wr_ptr_reg;
    logic [LEN_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [DATA_W-1:0] parity_reg;
    logic              done_reg, addr_err_reg;
    logic [DATA_W-1:0] header;
    logic [DATA_W-1:0] buf_rd_data;
    logic              start_ok, accept, last_load, last_pay;

    assign header    = make_header(len_reg, addr_reg);
    assign start_ok  = (state_reg == S_IDLE) && start && (dest_addr != ADDR_INVALID);
    assign accept    = (state_reg == S_LOAD) && pl_valid;
    assign last_load = accept && (wr_ptr_reg == len_reg - LEN_W'(1));
    assign last_pay  = (rd_ptr_reg == len_reg - LEN_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:    if (start_ok) state_next = (pay_len != '0) ? S_LOAD : S_HEADER;
            S_LOAD:    if (last_load) state_next = S_HEADER;
            S_HEADER:  if (!busy) state_next = (len_reg != '0) ? S_PAYLOAD : S_PARITY;
            S_PAYLOAD: if (!busy && last_pay) state_next = S_PARITY;
            S_PARITY:  if (!busy) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Every output is a decode of registered state/data, so nothing on the
    // router side moves while busy holds the FSM in place.
    always_comb begin
        pl_ready     = 1'b0;
        packet_valid = 1'b0;
        idle         = 1'b0;
        tx_data      = '0;
        case (state_reg)
            S_IDLE:    idle = 1'b1;
            S_LOAD:    pl_ready = 1'b1;
            S_HEADER: begin
                packet_valid = 1'b1;
                tx_data      = header;
            end
            S_PAYLOAD: begin
                packet_valid = 1'b1;
                tx_data      = buf_rd_data;
            end
            S_PARITY:  tx_data = parity_reg ^ {DATA_W{inj_reg}};
            default:   tx_data = '0;
        endcase
    end

    // Read address runs one step ahead so the RAM output already holds the
    // byte to present when PAYLOAD is entered or a byte has just transferred.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        if (start_ok) begin
            rd_ptr_next = '0;
        end else if ((state_reg == S_PAYLOAD) && !busy) begin
            rd_ptr_next = rd_ptr_reg + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_reg     <= '0;
            len_reg      <= '0;
            inj_reg      <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            parity_reg   <= '0;
            done_reg     <= 1'b0;
            addr_err_reg <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            done_reg     <= (state_reg == S_PARITY) && !busy;
            addr_err_reg <= (state_reg == S_IDLE) && start && (dest_addr == ADDR_INVALID);
            if (start_ok) begin
                addr_reg   <= dest_addr;
                len_reg    <= pay_len;
                inj_reg    <= inj_err;
                wr_ptr_reg <= '0;
                // Zero-length packets enter HEADER straight away, so the header folds in here.
                parity_reg <= (pay_len == '0) ? make_header(pay_len, dest_addr) : '0;
            end else if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + LEN_W'(1);
                parity_reg <= parity_reg ^ pl_data ^ ({DATA_W{last_load}} & header);
            end
        end
    end

    router_pkt_tx_buf #(
        .AW (BUF_AW),
        .DW (DATA_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (BUF_AW'(wr_ptr_reg)),
        .wr_data (pl_data),
        .rd_addr (BUF_AW'(rd_ptr_next)),
        .rd_data (buf_rd_data)
    );

    assign done     = done_reg;
    assign addr_err = addr_err_reg;

endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
- Packet source for the router input port; it is the transmitting end of the router's datain/packet_valid/busy protocol.
- Takes a transmit request (destination, payload length) and the payload bytes from an upstream valid/ready stream.
- Buffers the whole payload, then emits header, payload and parity back-to-back, honouring router busy stalls.
- The router protocol has no per-byte valid, so gaps inside a packet are illegal. Buffering guarantees a gap-free packet.

Parameters:
- BUF_AW, 6, payload buffer address width. Depth 2^BUF_AW must be >= 63 (max header length).

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- start  input  1  transmit request; sampled only in IDLE
- dest_addr  input  2  destination port 0..2; value 3 is illegal
- pay_len  input  6  payload byte count 0..63
- inj_err  input  1  sampled with start; corrupts the parity byte (inverted) for router err testing
- pl_valid  input  1  upstream payload byte valid
- pl_data  input  8  upstream payload byte
- pl_ready  output  1  payload byte accepted when pl_valid && pl_ready at a rising edge
- busy  input  1  router busy; a byte transfers only at a rising edge where busy==0
- tx_data  output  8  drives router datain
- packet_valid  output  1  drives router packet_valid
- idle  output  1  high in IDLE; start is accepted only then
- done  output  1  one-cycle pulse after the parity byte transfers
- addr_err  output  1  one-cycle pulse when start arrives with dest_addr==3

Behaviour:
- Reset (async, resetn low):
  - state=IDLE.
  - tx_data=0, packet_valid=0, pl_ready=0, done=0, addr_err=0, idle=1.
  - Counters and parity register cleared. Buffer contents are don't-care.
- Header byte = {pay_len, dest_addr}.
- Parity byte = XOR of header and all payload bytes; bitwise-inverted when inj_err was latched.
- Parity accumulates during LOAD; header is XORed in at HEADER entry.
- IDLE:
  - On start with dest_addr!=3: latch addr, len and inj_err; go to LOAD if len>0, else HEADER.
  - On start with dest_addr==3: pulse addr_err next cycle, remain IDLE.
- LOAD:
  - pl_ready=1.
  - Each accepted byte is written to buf[wr_ptr], wr_ptr++ and parity^=byte.
  - pl_valid gaps are allowed.
  - On acceptance of byte len-1, go to HEADER. pl_ready deasserts in the same cycle as the transition.
- HEADER: packet_valid=1, tx_data=header. At an edge with busy==0, go to PAYLOAD (len>0) or PARITY (len==0).
- PAYLOAD:
  - packet_valid=1, tx_data=buf[rd_ptr].
  - At an edge with busy==0, rd_ptr++.
  - After the last byte transfers, go to PARITY.
  - Buffer read is registered/prefetched so tx_data is valid in the same cycle the state is entered.
- PARITY:
  - packet_valid=0, tx_data=parity.
  - Held stable while busy==1.
  - At an edge with busy==0, go to IDLE and pulse done for one cycle.
- Stall rule: while busy==1, tx_data and packet_valid stay constant. No byte is skipped or duplicated.
- Outputs are registered. First header cycle is one clock after the LOAD→HEADER (or IDLE→HEADER) decision edge.
- Simultaneous events:
  - start outside IDLE is ignored.
  - pl_valid outside LOAD is ignored (pl_ready=0).
  - busy changes in IDLE/LOAD have no effect.
- Reset mid-packet: immediate return to reset values. The router sees packet_valid fall; no parity is sent for the aborted packet.
- Minimum packet time with busy=0 and no LOAD gaps: len (LOAD) + 1 (header) + len (payload) + 1 (parity) cycles.

Decomposition:
- Shared router package holds:
  - localparams DATA_W=8, LEN_W=6, ADDR_W=2, ADDR_INVALID=2'b11.
  - Header field positions (len [7:2], addr [1:0]).
  - State encoding: IDLE, LOAD, HEADER, PAYLOAD, PARITY.
- One sub-module: router_pkt_tx_buf, a 2^BUF_AW x 8 simple dual-port RAM (sync write, registered read).

Test Plan:
1. Basic packet:
   - Stimulus: reset, start addr=1 len=20, payload 0x01..0x14 with random pl_valid gaps, busy=0.
   - Required: header 0x51, 20 bytes in order with packet_valid=1, then parity 0x45 with packet_valid=0, done pulse, idle=1.
2. Zero length:
   - Stimulus: addr=2, len=0.
   - Required: pl_ready never high; header 0x02 then parity 0x02 on consecutive cycles.
3. Stall:
   - Stimulus: repeat case 1; raise busy for 3 cycles while payload byte 0x05 is presented, and for 2 cycles during parity.
   - Required: tx_data holds 0x05 then 0x45 during the stalls; exactly 22 transfers total.
4. Illegal address:
   - Stimulus: start addr=3 len=10.
   - Required: addr_err single pulse, pl_ready=0, packet_valid=0, idle stays 1.
5. Error injection:
   - Stimulus: case 1 with inj_err=1.
   - Required: parity byte 0xBA; all other bytes identical to case 1.
6. Reset mid-packet:
   - Stimulus: assert resetn=0 during payload byte 7.
   - Required: all outputs 0 and idle=1 asynchronously; a subsequent case-2 packet transmits correctly.
